traffic_light_monitor: RTL

- Checker and decoder on the output side of the two-road traffic light controller.
- Samples the six lamp drives (Ra/Ya/Ga, Rb/Yb/Gb) and decodes each road to a 2-bit light code.
- Tracks per-road light sequence and dwell time; raises sticky error flags on safety or protocol violations; counts completed road-A cycles.
- Sits beside the controller in the intersection top level; feeds status and diagnostics logic.

---
 rtl/traffic_light_monitor.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: decodes the six lamp drives of a two-road traffic
// light controller, tracks each road's light sequence and dwell time, raises
// sticky error flags and counts completed road-A cycles.
// Optional feature macro: TLM_FIRST_ERR_EN (adds first_err / first_err_cyc).
module traffic_light_monitor #(
  parameter int unsigned MIN_GREEN = 5,
  parameter int unsigned YEL_LEN   = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ra,
  input  logic             ya,
  input  logic             ga,
  input  logic             rb,
  input  logic             yb,
  input  logic             gb,
  input  logic             clr_err,
  output logic [1:0]       light_a,
  output logic [1:0]       light_b,
  output logic             err_conflict,
  output logic             err_onehot,
  output logic             err_seq,
  output logic             err_dwell,
  output logic             err_any,
  output logic [CNT_W-1:0] cyc_cnt
`ifdef TLM_FIRST_ERR_EN
  ,
  output logic [3:0]       first_err,
  output logic [CNT_W-1:0] first_err_cyc
`endif
);

  typedef enum logic [1:0] {UNK, RED, YEL, GRN} trk_t;

  typedef struct packed {
    trk_t             st;
    logic [CNT_W-1:0] cnt;
    logic             ok;
    logic             seq;
    logic             dwell;
    logic             rg;
  } trk_nx_t;

  localparam logic [CNT_W-1:0] MIN_G = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] YEL_L = CNT_W'(YEL_LEN);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  function automatic logic [1:0] decode(input logic r, input logic y, input logic g);
    case ({r, y, g})
      3'b100:  return 2'd0;
      3'b010:  return 2'd1;
      3'b001:  return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // One tracker step: next state, dwell count/qualifier and detected errors.
  function automatic trk_nx_t trk_step(input logic [1:0] code, input trk_t st,
                                       input logic [CNT_W-1:0] cnt, input logic ok);
    trk_nx_t nx;
    trk_t    tgt;
    logic    legal;
    nx.st    = UNK;
    nx.cnt   = '0;
    nx.ok    = 1'b0;
    nx.seq   = 1'b0;
    nx.dwell = 1'b0;
    nx.rg    = 1'b0;
    case (code)
      2'd0:    tgt = RED;
      2'd1:    tgt = YEL;
      2'd2:    tgt = GRN;
      default: tgt = UNK;
    endcase
    legal = (st == RED && tgt == GRN) || (st == GRN && tgt == YEL) ||
            (st == YEL && tgt == RED);
    if (tgt == UNK) begin
      nx.st = UNK;
    end else if (st == UNK) begin
      nx.st  = tgt;
      nx.cnt = ONE;
    end else if (tgt == st) begin
      nx.st  = st;
      nx.cnt = (cnt == '1) ? cnt : cnt + ONE;
      nx.ok  = ok;
    end else begin
      nx.st    = tgt;
      nx.cnt   = ONE;
      nx.ok    = legal;
      nx.seq   = !legal;
      nx.dwell = ok && ((st == GRN && tgt == YEL && cnt < MIN_G) ||
                        (st == YEL && tgt == RED && cnt != YEL_L));
      nx.rg    = legal && (st == RED);
    end
    return nx;
  endfunction

  logic [1:0]       code_a, code_b;
  trk_t             st_a, st_b;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic             ok_a, ok_b;
  trk_nx_t          nx_a, nx_b;
  logic [3:0]       det, flags, flags_nx;

  // Decode, tracker next-state and error detection for the current sample.
  always_comb begin
    code_a = decode(ra, ya, ga);
    code_b = decode(rb, yb, gb);
    nx_a   = trk_step(code_a, st_a, cnt_a, ok_a);
    nx_b   = trk_step(code_b, st_b, cnt_b, ok_b);
    det[0] = (code_a != 2'd3) && (code_b != 2'd3) &&
             (code_a != 2'd0) && (code_b != 2'd0);
    det[1] = (code_a == 2'd3) || (code_b == 2'd3);
    det[2] = nx_a.seq   || nx_b.seq;
    det[3] = nx_a.dwell || nx_b.dwell;
    flags  = {err_dwell, err_seq, err_onehot, err_conflict};
    // Detection wins over a coincident clear.
    flags_nx = (flags & ~{4{clr_err}}) | det;
  end

  // Tracker state, dwell counters and decoded light registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_a    <= UNK;
      st_b    <= UNK;
      cnt_a   <= '0;
      cnt_b   <= '0;
      ok_a    <= 1'b0;
      ok_b    <= 1'b0;
      light_a <= 2'd3;
      light_b <= 2'd3;
    end else begin
      st_a    <= nx_a.st;
      st_b    <= nx_b.st;
      cnt_a   <= nx_a.cnt;
      cnt_b   <= nx_b.cnt;
      ok_a    <= nx_a.ok;
      ok_b    <= nx_b.ok;
      light_a <= code_a;
      light_b <= code_b;
    end
  end

  // Sticky error flags, their OR, and the road-A cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {err_dwell, err_seq, err_onehot, err_conflict} <= '0;
      err_any <= 1'b0;
      cyc_cnt <= '0;
    end else begin
      {err_dwell, err_seq, err_onehot, err_conflict} <= flags_nx;
      err_any <= |flags_nx;
      if (nx_a.rg && cyc_cnt != '1) cyc_cnt <= cyc_cnt + ONE;
    end
  end

`ifdef TLM_FIRST_ERR_EN
  // Snapshot of the first error set and the cycle count when it appeared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_err     <= '0;
      first_err_cyc <= '0;
    end else if (|det && (!err_any || clr_err)) begin
      first_err     <= det;
      first_err_cyc <= cyc_cnt;
    end else if (clr_err) begin
      first_err     <= '0;
      first_err_cyc <= '0;
    end
  end
`endif

endmodule
